// File: rtl/id_rename_stage_pkg.sv
// id_pkg: shared widths and decoded/dispatch record types for the rename stage
package id_pkg;
  localparam int ISSUE_W = 2;
  localparam int XLEN = 32;
  localparam int REG_N = 32;
  localparam int TAG_W = 4;
  localparam int CDB_N = 2;
  localparam int EX_UNIT_NUM = 4;
  localparam int OP_W = 6;
  localparam int RIDX_W = $clog2(REG_N);
  localparam int CNT_W = $clog2(ISSUE_W + 1);
  localparam int UNIT_W = $clog2(EX_UNIT_NUM);
  typedef struct packed {
    logic v;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [RIDX_W-1:0] rd;
    logic rd_ce;
    logic pc_sel;
    logic imm_sel;
    logic [UNIT_W-1:0] unit;
    logic [OP_W-1:0] op;
  } slot_t;
  typedef struct packed {
    logic v;
    logic [UNIT_W-1:0] unit;
    logic [OP_W-1:0] op;
    logic [TAG_W-1:0] target;
    logic [TAG_W-1:0] tag1;
    logic [TAG_W-1:0] tag2;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
  } dispatch_t;
endpackage

// File: rtl/id_rename_stage_if.sv
// id_rename_stage_if: decode group in, ROB/RS credits, CDB broadcasts and dispatch group out
interface id_rename_stage_if;
  import id_pkg::*;
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [ISSUE_W-1:0] in_slot_v, in_rd_ce, in_pc_sel, in_imm_sel, out_slot_v;
  logic [ISSUE_W-1:0][XLEN-1:0] in_pc, in_imm, out_val1, out_val2;
  logic [ISSUE_W-1:0][RIDX_W-1:0] in_rs1, in_rs2, in_rd;
  logic [ISSUE_W-1:0][UNIT_W-1:0] in_unit, out_unit;
  logic [ISSUE_W-1:0][OP_W-1:0] in_op, out_op;
  logic [ISSUE_W-1:0][TAG_W-1:0] rob_tag, out_target, out_tag1, out_tag2;
  logic [CNT_W-1:0] rob_free_cnt;
  logic [EX_UNIT_NUM-1:0][CNT_W-1:0] rs_free_cnt;
  logic [CDB_N-1:0] cdb_v;
  logic [CDB_N-1:0][TAG_W-1:0] cdb_tag;
  logic [CDB_N-1:0][XLEN-1:0] cdb_data;
  modport master (
    output flush, in_valid, in_slot_v, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rd_ce,
           in_pc_sel, in_imm_sel, in_unit, in_op, rob_tag, rob_free_cnt, rs_free_cnt,
           cdb_v, cdb_tag, cdb_data, out_ready,
    input  in_ready, out_valid, out_slot_v, out_unit, out_op, out_target,
           out_val1, out_val2, out_tag1, out_tag2
  );
  modport slave (
    input  flush, in_valid, in_slot_v, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rd_ce,
           in_pc_sel, in_imm_sel, in_unit, in_op, rob_tag, rob_free_cnt, rs_free_cnt,
           cdb_v, cdb_tag, cdb_data, out_ready,
    output in_ready, out_valid, out_slot_v, out_unit, out_op, out_target,
           out_val1, out_val2, out_tag1, out_tag2
  );
endinterface

// File: rtl/id_rename_stage_rename_table.sv
// rename_table: per-register busy tag and value, CDB writeback, read ports with CDB bypass
module rename_table import id_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic [2*ISSUE_W-1:0][RIDX_W-1:0] ra,
  output logic [2*ISSUE_W-1:0][XLEN-1:0] rv,
  output logic [2*ISSUE_W-1:0][TAG_W-1:0] rt,
  input  logic [ISSUE_W-1:0] we,
  input  logic [ISSUE_W-1:0][RIDX_W-1:0] wa,
  input  logic [ISSUE_W-1:0][TAG_W-1:0] wt,
  input  logic [CDB_N-1:0] cdb_v,
  input  logic [CDB_N-1:0][TAG_W-1:0] cdb_tag,
  input  logic [CDB_N-1:0][XLEN-1:0] cdb_data
);
  logic [REG_N-1:0][TAG_W-1:0] busy;
  logic [REG_N-1:0][XLEN-1:0] value;
  // x0 is never renamed nor written, so its entry reads as value 0, tag 0
  always_comb begin
    rv = '0;
    rt = '0;
    for (int p = 0; p < 2*ISSUE_W; p++) begin
      rv[p] = busy[ra[p]] == '0 ? value[ra[p]] : '0;
      rt[p] = busy[ra[p]];
      for (int c = 0; c < CDB_N; c++)
        if (busy[ra[p]] != '0 && cdb_v[c] && cdb_tag[c] == busy[ra[p]]) begin
          rv[p] = cdb_data[c];
          rt[p] = '0;
        end
    end
  end
  // renames are applied after CDB clears so a same-cycle rename keeps its new tag
  always_ff @(posedge clk)
    if (rst) begin
      busy <= '0;
      value <= '0;
    end else if (flush) busy <= '0;
    else begin
      for (int r = 0; r < REG_N; r++)
        for (int c = 0; c < CDB_N; c++)
          if (cdb_v[c] && busy[r] != '0 && busy[r] == cdb_tag[c]) begin
            value[r] <= cdb_data[c];
            busy[r] <= '0;
          end
      for (int s = 0; s < ISSUE_W; s++)
        if (we[s] && wa[s] != '0) busy[wa[s]] <= wt[s];
    end
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < CDB_N; i++)
        for (int j = i + 1; j < CDB_N; j++)
          assert (!(cdb_v[i] && cdb_v[j] && cdb_tag[i] == cdb_tag[j]));
endmodule

// File: rtl/id_rename_stage.sv
// id_rename_stage: resource-gated rename/dispatch of a decode group into the IDEX register
module id_rename_stage import id_pkg::*; (
  input logic clk,
  input logic rst,
  id_rename_stage_if.slave bus
);
  slot_t [ISSUE_W-1:0] s;
  dispatch_t [ISSUE_W-1:0] d, q;
  logic q_valid, res_ok, accept;
  logic [ISSUE_W-1:0] w;
  logic [ISSUE_W-1:0][TAG_W-1:0] tgt, fq;
  logic [CNT_W-1:0] need_rob;
  logic [EX_UNIT_NUM-1:0][CNT_W-1:0] need_rs;
  logic [2*ISSUE_W-1:0][RIDX_W-1:0] ra;
  logic [2*ISSUE_W-1:0][XLEN-1:0] rv;
  logic [2*ISSUE_W-1:0][TAG_W-1:0] rt;
  always_comb begin
    s = '0;
    ra = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      s[i] = '{v: bus.in_slot_v[i], pc: bus.in_pc[i], imm: bus.in_imm[i], rs1: bus.in_rs1[i],
               rs2: bus.in_rs2[i], rd: bus.in_rd[i], rd_ce: bus.in_rd_ce[i],
               pc_sel: bus.in_pc_sel[i], imm_sel: bus.in_imm_sel[i], unit: bus.in_unit[i],
               op: bus.in_op[i]};
      ra[2*i] = bus.in_rs1[i];
      ra[2*i+1] = bus.in_rs2[i];
    end
  end
  // free ROB tags are consumed in slot order by writing slots only
  always_comb begin
    need_rob = '0;
    need_rs = '0;
    fq = bus.rob_tag;
    w = '0;
    tgt = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      w[i] = s[i].v & s[i].rd_ce;
      tgt[i] = w[i] ? fq[0] : '0;
      fq = w[i] ? fq >> TAG_W : fq;
      need_rob = need_rob + CNT_W'(w[i]);
      if (s[i].v) need_rs[s[i].unit] = need_rs[s[i].unit] + CNT_W'(1);
    end
    res_ok = bus.rob_free_cnt >= need_rob;
    for (int u = 0; u < EX_UNIT_NUM; u++) res_ok = res_ok & (bus.rs_free_cnt[u] >= need_rs[u]);
  end
  assign bus.in_ready = !rst && !bus.flush && (!q_valid || bus.out_ready) && res_ok;
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    d = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      d[i] = '{v: s[i].v, unit: s[i].unit, op: s[i].op, target: tgt[i], tag1: rt[2*i],
               tag2: rt[2*i+1], val1: rv[2*i], val2: rv[2*i+1]};
      for (int j = 0; j < i; j++)
        if (w[j] && s[j].rd != '0) begin
          if (s[j].rd == s[i].rs1) {d[i].tag1, d[i].val1} = {tgt[j], XLEN'(0)};
          if (s[j].rd == s[i].rs2) {d[i].tag2, d[i].val2} = {tgt[j], XLEN'(0)};
        end
      if (s[i].pc_sel) {d[i].tag1, d[i].val1} = {TAG_W'(0), s[i].pc};
      if (s[i].imm_sel) {d[i].tag2, d[i].val2} = {TAG_W'(0), s[i].imm};
      if (!s[i].v) d[i] = '0;
    end
  end
  rename_table u_table (
    .clk(clk), .rst(rst), .flush(bus.flush), .ra(ra), .rv(rv), .rt(rt),
    .we(accept ? w : '0), .wa(bus.in_rd), .wt(tgt),
    .cdb_v(bus.cdb_v), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data)
  );
  // a held group keeps snooping the CDB while IDEX stalls
  always_ff @(posedge clk)
    if (rst) begin
      q <= '0;
      q_valid <= 1'b0;
    end else if (bus.flush) q_valid <= 1'b0;
    else if (accept) begin
      q <= d;
      q_valid <= 1'b1;
    end else begin
      if (bus.out_ready) q_valid <= 1'b0;
      for (int i = 0; i < ISSUE_W; i++)
        for (int c = 0; c < CDB_N; c++) begin
          if (q[i].tag1 != '0 && bus.cdb_v[c] && bus.cdb_tag[c] == q[i].tag1) begin
            q[i].tag1 <= '0;
            q[i].val1 <= bus.cdb_data[c];
          end
          if (q[i].tag2 != '0 && bus.cdb_v[c] && bus.cdb_tag[c] == q[i].tag2) begin
            q[i].tag2 <= '0;
            q[i].val2 <= bus.cdb_data[c];
          end
        end
    end
  always_comb begin
    bus.out_valid = q_valid;
    bus.out_slot_v = '0;
    bus.out_unit = '0;
    bus.out_op = '0;
    bus.out_target = '0;
    bus.out_val1 = '0;
    bus.out_val2 = '0;
    bus.out_tag1 = '0;
    bus.out_tag2 = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      bus.out_slot_v[i] = q[i].v;
      bus.out_unit[i] = q[i].unit;
      bus.out_op[i] = q[i].op;
      bus.out_target[i] = q[i].target;
      bus.out_val1[i] = q[i].val1;
      bus.out_val2[i] = q[i].val2;
      bus.out_tag1[i] = q[i].tag1;
      bus.out_tag2[i] = q[i].tag2;
    end
  end
endmodule

// File: tb/tb_id_rename_stage.sv
// tb_id_rename_stage: directed scenario tests of rename, forwarding, CDB snoop, gating and flush
module tb_id_rename_stage;
  import id_pkg::*;
  logic clk, rst;
  int checks = 0, errors = 0;
  id_rename_stage_if bus();
  id_rename_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    bus.flush = 0;
    bus.in_valid = 0;
    bus.in_slot_v = '0;
    bus.in_rd_ce = '0;
    bus.in_pc_sel = '0;
    bus.in_imm_sel = '0;
    bus.in_pc = '0;
    bus.in_imm = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_rd = '0;
    bus.in_unit = '0;
    bus.in_op = '0;
    bus.cdb_v = '0;
    bus.cdb_tag = '0;
    bus.cdb_data = '0;
  endtask
  task automatic set_slot(input int i, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic ce, input logic [1:0] unit,
                          input logic [3:0] tag);
    bus.in_slot_v[i] = 1;
    bus.in_rs1[i] = rs1;
    bus.in_rs2[i] = rs2;
    bus.in_rd[i] = rd;
    bus.in_rd_ce[i] = ce;
    bus.in_unit[i] = unit;
    bus.in_op[i] = 6'(i + 1);
    bus.rob_tag[i] = tag;
    bus.in_valid = 1;
  endtask
  task automatic test_reset();
    clear();
    bus.out_ready = 1;
    bus.rob_free_cnt = 2;
    bus.rs_free_cnt = {4{2'd2}};
    bus.rob_tag = '0;
    rst = 1;
    step();
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_target !== '0 || bus.out_val1 !== '0) begin errors++; $display("FAIL reset_out_fields got=%h/%h exp=0", bus.out_target, bus.out_val1); end
    rst = 0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", bus.in_ready); end
  endtask
  task automatic test_basic();
    clear();
    set_slot(0, 1, 2, 5, 1, 0, 3);
    step();
    clear();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.out_target[0] !== 4'd3 || bus.out_slot_v !== 2'b01) begin errors++; $display("FAIL basic_target got=%0d/%b exp=3/01", bus.out_target[0], bus.out_slot_v); end
    checks++; if (bus.out_tag1[0] !== 0 || bus.out_tag2[0] !== 0 || bus.out_val1[0] !== 0 || bus.out_val2[0] !== 0) begin errors++; $display("FAIL basic_operands got=%0d,%0d,%h,%h exp=0", bus.out_tag1[0], bus.out_tag2[0], bus.out_val1[0], bus.out_val2[0]); end
  endtask
  task automatic test_snoop();
    set_slot(0, 5, 0, 6, 1, 0, 1);
    step();
    clear();
    bus.out_ready = 0;
    checks++; if (bus.out_tag1[0] !== 4'd3) begin errors++; $display("FAIL snoop_tag1 got=%0d exp=3", bus.out_tag1[0]); end
    set_slot(0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%0b exp=0", bus.in_ready); end
    clear();
    bus.cdb_v[0] = 1;
    bus.cdb_tag[0] = 3;
    bus.cdb_data[0] = 32'hAB;
    step();
    clear();
    checks++; if (bus.out_val1[0] !== 32'hAB || bus.out_tag1[0] !== 0) begin errors++; $display("FAIL snoop_val got=%h/%0d exp=ab/0", bus.out_val1[0], bus.out_tag1[0]); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL snoop_held got=%0b exp=1", bus.out_valid); end
    bus.out_ready = 1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%0b exp=0", bus.out_valid); end
  endtask
  task automatic test_group();
    set_slot(0, 1, 0, 7, 1, 0, 4);
    set_slot(1, 7, 5, 8, 1, 1, 5);
    step();
    clear();
    checks++; if (bus.out_target[0] !== 4'd4 || bus.out_target[1] !== 4'd5) begin errors++; $display("FAIL group_targets got=%0d,%0d exp=4,5", bus.out_target[0], bus.out_target[1]); end
    checks++; if (bus.out_tag1[1] !== 4'd4) begin errors++; $display("FAIL group_forward got=%0d exp=4", bus.out_tag1[1]); end
    checks++; if (bus.out_val2[1] !== 32'hAB || bus.out_tag2[1] !== 0) begin errors++; $display("FAIL group_x5 got=%h/%0d exp=ab/0", bus.out_val2[1], bus.out_tag2[1]); end
    set_slot(0, 7, 8, 0, 0, 0, 1);
    step();
    clear();
    checks++; if (bus.out_tag1[0] !== 4'd4 || bus.out_tag2[0] !== 4'd5 || bus.out_target[0] !== 0) begin errors++; $display("FAIL group_busy got=%0d,%0d,%0d exp=4,5,0", bus.out_tag1[0], bus.out_tag2[0], bus.out_target[0]); end
  endtask
  task automatic test_resource();
    set_slot(0, 0, 0, 10, 1, 1, 8);
    set_slot(1, 0, 0, 11, 1, 1, 9);
    bus.rob_free_cnt = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rob_gate got=%0b exp=0", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rob_gate_valid got=%0b exp=0", bus.out_valid); end
    bus.rob_free_cnt = 2;
    bus.rs_free_cnt[1] = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rs_gate got=%0b exp=0", bus.in_ready); end
    bus.rs_free_cnt[1] = 2;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL gate_open got=%0b exp=1", bus.in_ready); end
    step();
    clear();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_target[0] !== 4'd8 || bus.out_target[1] !== 4'd9) begin errors++; $display("FAIL gate_accept got=%0b %0d,%0d exp=1 8,9", bus.out_valid, bus.out_target[0], bus.out_target[1]); end
  endtask
  task automatic test_rename_race();
    set_slot(0, 0, 0, 9, 1, 0, 2);
    step();
    clear();
    set_slot(0, 9, 0, 9, 1, 0, 6);
    bus.cdb_v[1] = 1;
    bus.cdb_tag[1] = 2;
    bus.cdb_data[1] = 32'h55;
    step();
    clear();
    checks++; if (bus.out_val1[0] !== 32'h55 || bus.out_tag1[0] !== 0 || bus.out_target[0] !== 4'd6) begin errors++; $display("FAIL race_bypass got=%h/%0d/%0d exp=55/0/6", bus.out_val1[0], bus.out_tag1[0], bus.out_target[0]); end
    set_slot(0, 9, 0, 0, 0, 0, 1);
    step();
    clear();
    checks++; if (bus.out_tag1[0] !== 4'd6) begin errors++; $display("FAIL race_keep got=%0d exp=6", bus.out_tag1[0]); end
    bus.cdb_v[0] = 1;
    bus.cdb_tag[0] = 6;
    bus.cdb_data[0] = 32'h66;
    step();
    clear();
    set_slot(0, 9, 0, 0, 0, 0, 1);
    step();
    clear();
    checks++; if (bus.out_val1[0] !== 32'h66 || bus.out_tag1[0] !== 0) begin errors++; $display("FAIL race_writeback got=%h/%0d exp=66/0", bus.out_val1[0], bus.out_tag1[0]); end
  endtask
  task automatic test_flush();
    set_slot(0, 0, 0, 12, 1, 0, 10);
    step();
    clear();
    bus.out_ready = 0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got=%0b exp=1", bus.out_valid); end
    set_slot(0, 0, 0, 13, 1, 0, 11);
    bus.flush = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b exp=0", bus.in_ready); end
    step();
    clear();
    bus.out_ready = 1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", bus.out_valid); end
    set_slot(0, 12, 8, 0, 1, 0, 12);
    set_slot(1, 9, 13, 0, 0, 0, 1);
    step();
    clear();
    checks++; if (bus.out_tag1[0] !== 0 || bus.out_tag2[0] !== 0 || bus.out_tag2[1] !== 0) begin errors++; $display("FAIL flush_busy got=%0d,%0d,%0d exp=0", bus.out_tag1[0], bus.out_tag2[0], bus.out_tag2[1]); end
    checks++; if (bus.out_val1[1] !== 32'h66) begin errors++; $display("FAIL flush_values got=%h exp=66", bus.out_val1[1]); end
    set_slot(0, 0, 0, 0, 0, 0, 1);
    bus.in_pc_sel[0] = 1;
    bus.in_imm_sel[0] = 1;
    bus.in_pc[0] = 32'h200;
    bus.in_imm[0] = 32'h33;
    set_slot(1, 0, 0, 0, 0, 0, 1);
    step();
    clear();
    checks++; if (bus.out_val1[0] !== 32'h200 || bus.out_val2[0] !== 32'h33) begin errors++; $display("FAIL pc_imm_sel got=%h,%h exp=200,33", bus.out_val1[0], bus.out_val2[0]); end
    checks++; if (bus.out_tag1[1] !== 0 || bus.out_val1[1] !== 0) begin errors++; $display("FAIL x0_not_renamed got=%0d/%h exp=0/0", bus.out_tag1[1], bus.out_val1[1]); end
  endtask
  task automatic test_back_to_back();
    set_slot(0, 0, 0, 14, 1, 2, 13);
    step();
    clear();
    set_slot(0, 14, 0, 15, 1, 2, 14);
    step();
    clear();
    checks++; if (bus.out_tag1[0] !== 4'd13 || bus.out_target[0] !== 4'd14 || bus.out_unit[0] !== 2'd2) begin errors++; $display("FAIL b2b got=%0d,%0d,%0d exp=13,14,2", bus.out_tag1[0], bus.out_target[0], bus.out_unit[0]); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_snoop();
    test_group();
    test_resource();
    test_rename_race();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
